sig_activity_ctrl: RTL and testbench
====================================

SIG_ACTIVITY_CTRL -- requirements
Module: sig_activity_ctrl

Interface
REQ-001 Parameters SHALL be: N_CH, default 4, number of monitored inputs; CNT_W, default 16, timeout counter width.
REQ-002 Ports SHALL be, in order:
- clk  in  1  system clock.
- resetn  in  1  synchronous active-low reset.
- in  in  N_CH  asynchronous monitored signals.
- cfg_timeout  in  CNT_W  new timeout value, in clk cycles.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration accepted when high together with cfg_valid.
- active  out  N_CH  per-channel activity flag.
- status_change  out  N_CH  per-channel pending-change flags.
- irq  out  1  interrupt request.
- irq_ack  in  1  interrupt acknowledge pulse.
REQ-003 All ports SHALL be synchronous to clk, except in.

Function
REQ-004 Each channel SHALL pass in[i] through a 2-flop synchronizer followed by one history flop; an edge SHALL be defined as sync output != history flop.
REQ-005 Each channel SHALL own a CNT_W-bit down-counter; active[i] SHALL equal (cnt[i] != 0).
REQ-006 In RUN, a channel counter SHALL take the following next values, in priority order:
- edge: the captured timeout (tmo_q).
- else cnt>0: cnt-1.
- else: hold at 0, with no wrap.
REQ-007 An edge coincident with cnt==1 or cnt==0 SHALL reload tmo_q, so active does not drop.
REQ-008 An input change SHALL assert active on the 3rd rising clk edge after the change is sampled. Active SHALL deassert exactly tmo_q cycles after the last edge load.
REQ-009 The controller FSM SHALL have exactly three states: DISABLED, LOAD and RUN.
REQ-010 DISABLED: counters held at 0 and cfg_ready=1. cfg_valid SHALL capture cfg_timeout into tmo_q and move to LOAD.
REQ-011 LOAD: lasts exactly one cycle, cfg_ready=0, all counters cleared to 0. The next state SHALL be RUN if tmo_q!=0, else DISABLED.
REQ-012 RUN: cfg_ready=1. cfg_valid SHALL capture a new tmo_q and move to LOAD. Edges SHALL be processed per REQ-006.
REQ-013 The synchronizer and history flops SHALL run in every state, so no false edge occurs on entry to RUN.
REQ-014 change_pend[i] SHALL set when active[i] differs from its value on the previous cycle, in either direction. status_change SHALL equal change_pend.
REQ-015 irq SHALL equal the OR-reduction of change_pend, registered.
REQ-016 irq_ack SHALL clear all change_pend bits, except any bit that is setting in the same cycle; setting wins.
REQ-017 Active transitions caused by the LOAD clear SHALL set change_pend.

Reset
REQ-018 With resetn low at a rising clk edge, the following SHALL take these values:
- state=DISABLED.
- tmo_q=0.
- all counters, synchronizer and history flops = 0.
- active=0, change_pend=0, irq=0, cfg_ready=0.
REQ-019 cfg_ready SHALL be 1 on the first cycle after resetn is released.
REQ-020 Reset during RUN or LOAD SHALL abandon the operation. No configuration SHALL be retained.

Configuration
REQ-021 With macro SIG_ACTIVITY_IRQ_EN defined, REQ-014 to REQ-017 SHALL be implemented.
REQ-022 Without SIG_ACTIVITY_IRQ_EN, the change_pend logic SHALL be omitted, status_change and irq SHALL be tied to 0, and irq_ack SHALL be ignored. All other behaviour SHALL be identical.

Structure
REQ-023 Package sig_activity_pkg SHALL hold:
- the state enum type (DISABLED, LOAD, RUN).
- default N_CH and CNT_W constants.
REQ-024 Sub-module sig_activity_chan SHALL implement one channel: synchronizer, history flop, edge detect and counter.
REQ-025 sig_activity_chan SHALL take clk, resetn, in, tmo, run and clr, and SHALL output active. The top SHALL instantiate N_CH copies.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Reset, then cfg_timeout=5 with cfg_valid for 1 cycle -> cfg_ready low for 1 cycle (LOAD), then state RUN, active=0.
- tmo=5, single rising edge on in[0] -> active[0] high on the 3rd edge, low exactly 5 cycles later; irq rises on each change; status_change[0]=1.
- tmo=5, in[1] toggled every 4 cycles -> active[1] stays continuously high (reload at cnt==1/0); other channels stay 0.
- Pending change plus irq_ack in the same cycle as a new active[2] transition -> change_pend[2] stays set and irq stays 1; bits not re-setting clear.
- In RUN with active=4'b1111, apply cfg_timeout=0 -> all active clear in LOAD, then state DISABLED, cfg_ready=1; later edges give active=0.
- resetn low for 1 cycle mid-count (cnt=3) -> all outputs 0 next cycle, tmo_q=0. Build without SIG_ACTIVITY_IRQ_EN -> irq=0 under every scenario above.

Source files
------------

// File: rtl/sig_activity_pkg.sv
// Shared types and default sizes for the signal-activity controller.
// Interrupt logic in the top is enabled with the SIG_ACTIVITY_IRQ_EN macro.
package sig_activity_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    LOAD     = 2'd1,
    RUN      = 2'd2
  } state_t;

endpackage

// File: rtl/sig_activity_chan.sv
// One monitored channel: 2-flop synchronizer, history flop, edge detect and
// a retriggerable down-counter whose non-zero value is the activity flag.
module sig_activity_chan
  import sig_activity_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in,
  input  logic [CNT_W-1:0] tmo,
  input  logic             run,
  input  logic             clr,
  output logic             active
);

  logic             sync_p0;
  logic             sync_p1;
  logic             hist_p2;
  logic             edge_det;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  assign edge_det = sync_p1 ^ hist_p2;
  assign active   = (cnt != '0);

  // Edge reload takes priority, so an edge at cnt==1 or cnt==0 keeps active high.
  always_comb begin
    cnt_next = cnt;
    if (clr || !run) begin
      cnt_next = '0;
    end else if (edge_det) begin
      cnt_next = tmo;
    end else if (cnt != '0) begin
      cnt_next = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      hist_p2 <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_p0 <= in;
      sync_p1 <= sync_p0;
      hist_p2 <= sync_p1;
      cnt     <= cnt_next;
    end
  end

endmodule

// File: rtl/sig_activity_ctrl.sv
// Multi-channel activity monitor with a DISABLED/LOAD/RUN configuration FSM.
// Define SIG_ACTIVITY_IRQ_EN to build the change-pending flags and irq output.
module sig_activity_ctrl
  import sig_activity_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_CH-1:0]  in,
  input  logic [CNT_W-1:0] cfg_timeout,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic [N_CH-1:0]  active,
  output logic [N_CH-1:0]  status_change,
  output logic             irq,
  input  logic             irq_ack
);

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] tmo_q;
  logic             cfg_take;
  logic             run;
  logic             clr;

  always_comb begin
    state_d  = state;
    cfg_take = 1'b0;
    case (state)
      DISABLED, RUN: begin
        if (cfg_valid && cfg_ready) begin
          cfg_take = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD:    state_d = (tmo_q != '0) ? RUN : DISABLED;
      default: state_d = DISABLED;
    endcase
  end

  // cfg_ready is registered so it stays low throughout reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= DISABLED;
      tmo_q     <= '0;
      cfg_ready <= 1'b0;
    end else begin
      state     <= state_d;
      cfg_ready <= (state_d != LOAD);
      if (cfg_take) begin
        tmo_q <= cfg_timeout;
      end
    end
  end

  assign run = (state == RUN);
  assign clr = (state == LOAD);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    sig_activity_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk    (clk),
      .resetn (resetn),
      .in     (in[i]),
      .tmo    (tmo_q),
      .run    (run),
      .clr    (clr),
      .active (active[i])
    );
  end

`ifdef SIG_ACTIVITY_IRQ_EN
  logic [N_CH-1:0] active_prev;
  logic [N_CH-1:0] change_pend;
  logic [N_CH-1:0] change_set;

  // A bit that is setting this cycle survives a simultaneous acknowledge.
  assign change_set    = active ^ active_prev;
  assign status_change = change_pend;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      active_prev <= '0;
      change_pend <= '0;
      irq         <= 1'b0;
    end else begin
      active_prev <= active;
      change_pend <= change_set | (change_pend & {N_CH{~irq_ack}});
      irq         <= |change_pend;
    end
  end
`else
  logic ack_unused;

  assign ack_unused    = irq_ack;
  assign status_change = '0;
  assign irq           = 1'b0;
`endif

endmodule

// File: tb/tb_sig_activity_ctrl.sv
// Directed plus randomized bench for sig_activity_ctrl against a deadline-based model.
module tb_sig_activity_ctrl;

  localparam int N_CH  = 4;
  localparam int CNT_W = 16;
  localparam int M_DIS  = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;

  logic             clk = 1'b0;
  logic             resetn;
  logic [N_CH-1:0]  in;
  logic [CNT_W-1:0] cfg_timeout;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [N_CH-1:0]  active;
  logic [N_CH-1:0]  status_change;
  logic             irq;
  logic             irq_ack;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sig_activity_ctrl #(
    .N_CH  (N_CH),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .in            (in),
    .cfg_timeout   (cfg_timeout),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .active        (active),
    .status_change (status_change),
    .irq           (irq),
    .irq_ack       (irq_ack)
  );

  // Reference model: each channel is active while the edge count is below an
  // absolute deadline = (edge at which the input change was detected) + timeout.
  logic [N_CH-1:0] smp_q[$];
  longint          n_edge = 0;
  longint          deadline[N_CH];
  int              m_mode = M_DIS;
  longint          m_tmo  = 0;
  logic [N_CH-1:0] m_act     = '0;
  logic [N_CH-1:0] m_actprev = '0;
  logic [N_CH-1:0] m_pend    = '0;
  logic            m_irq     = 1'b0;
  logic            m_ready   = 1'b0;

  function automatic logic [N_CH-1:0] past(input int back);
    int idx;
    idx = smp_q.size() - back;
    if (idx < 0) return '0;
    return smp_q[idx];
  endfunction

  task automatic model_step();
    logic [N_CH-1:0] edges;
    logic [N_CH-1:0] old_act;
    logic            accepted;
    n_edge++;
    if (!resetn) begin
      smp_q.delete();
      m_mode = M_DIS;
      m_tmo  = 0;
      for (int i = 0; i < N_CH; i++) deadline[i] = 0;
      m_act = '0; m_actprev = '0; m_pend = '0; m_irq = 1'b0; m_ready = 1'b0;
      return;
    end
    // An input change sampled at edge k is seen as an edge at k+2.
    edges = past(2) ^ past(3);
    smp_q.push_back(in);
    if (smp_q.size() > 8) void'(smp_q.pop_front());
    accepted = cfg_valid && m_ready;
    old_act  = m_act;
    case (m_mode)
      M_DIS: begin
        for (int i = 0; i < N_CH; i++) deadline[i] = 0;
        if (accepted) begin m_tmo = longint'(cfg_timeout); m_mode = M_LOAD; end
      end
      M_LOAD: begin
        for (int i = 0; i < N_CH; i++) deadline[i] = 0;
        m_mode = (m_tmo != 0) ? M_RUN : M_DIS;
      end
      default: begin
        for (int i = 0; i < N_CH; i++) if (edges[i]) deadline[i] = n_edge + m_tmo;
        if (accepted) begin m_tmo = longint'(cfg_timeout); m_mode = M_LOAD; end
      end
    endcase
    for (int i = 0; i < N_CH; i++) m_act[i] = (n_edge < deadline[i]);
    m_ready = (m_mode != M_LOAD);
`ifdef SIG_ACTIVITY_IRQ_EN
    m_irq     = |m_pend;
    m_pend    = (m_pend & ~{N_CH{irq_ack}}) | (old_act ^ m_actprev);
    m_actprev = old_act;
`else
    m_irq  = 1'b0;
    m_pend = '0;
`endif
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("model_active", 32'(active), 32'(m_act));
    chk("model_status_change", 32'(status_change), 32'(m_pend));
    chk("model_irq", 32'(irq), 32'(m_irq));
    chk("model_cfg_ready", 32'(cfg_ready), 32'(m_ready));
  endtask

  initial begin
    resetn = 1'b0; in = '0; cfg_timeout = '0; cfg_valid = 1'b0; irq_ack = 1'b0;
    repeat (3) cycle();
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    resetn = 1'b1;
    cycle();
    chk("ready_after_rst", 32'(cfg_ready), 32'd1);

    // Configure tmo=5: one LOAD cycle, then RUN
    cfg_timeout = 16'd5; cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    chk("load_ready_low", 32'(cfg_ready), 32'd0);
    cycle();
    chk("run_ready_high", 32'(cfg_ready), 32'd1);
    chk("run_active_zero", 32'(active), 32'd0);

    // Single rising edge on in[0]
    in[0] = 1'b1;
    cycle(); cycle();
    chk("act0_before_3rd", 32'(active[0]), 32'd0);
    cycle();
    chk("act0_on_3rd", 32'(active[0]), 32'd1);
    repeat (4) cycle();
    chk("act0_hold", 32'(active[0]), 32'd1);
    cycle();
    chk("act0_fall", 32'(active[0]), 32'd0);
    cycle();
`ifdef SIG_ACTIVITY_IRQ_EN
    chk("sc0_pending", 32'(status_change[0]), 32'd1);
    chk("irq_pending", 32'(irq), 32'd1);
`else
    chk("sc0_tied", 32'(status_change), 32'd0);
    chk("irq_tied", 32'(irq), 32'd0);
`endif

    // in[1] toggled every 4 cycles keeps active[1] high
    for (int k = 0; k < 6; k++) begin
      in[1] = ~in[1];
      for (int c = 0; c < 4; c++) begin
        cycle();
        if (k > 0 || c >= 2) chk("act1_continuous", 32'(active[1]), 32'd1);
        chk("others_idle", 32'({active[3:2], active[0]}), 32'd0);
      end
    end
    repeat (12) cycle();

    // Acknowledge coinciding with a new active[2] transition
    in[3] = 1'b1;
    cycle(); cycle();
    in[2] = 1'b1;
    cycle(); cycle(); cycle();
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
`ifdef SIG_ACTIVITY_IRQ_EN
    chk("ack_keeps_setting_bit", 32'(status_change), 32'h4);
    chk("ack_irq_stays", 32'(irq), 32'd1);
`else
    chk("ack_irq_tied", 32'(irq), 32'd0);
`endif
    repeat (10) cycle();
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
    repeat (10) cycle();

    // All four active, then cfg_timeout=0 disables
    in = ~in;
    repeat (3) cycle();
    chk("all_active", 32'(active), 32'hF);
    cfg_timeout = 16'd0; cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    chk("zero_cfg_load_ready", 32'(cfg_ready), 32'd0);
    chk("zero_cfg_still_active", 32'(active), 32'hF);
    cycle();
    chk("load_clears_active", 32'(active), 32'd0);
    chk("disabled_ready", 32'(cfg_ready), 32'd1);
    in = ~in;
    repeat (6) cycle();
    chk("disabled_no_activity", 32'(active), 32'd0);

    // Reset mid-count (cnt=3)
    cfg_timeout = 16'd5; cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    cycle();
    in[0] = ~in[0];
    repeat (5) cycle();
    chk("midcount_active", 32'(active[0]), 32'd1);
    resetn = 1'b0;
    cycle();
    chk("midrst_active", 32'(active), 32'd0);
    chk("midrst_status", 32'(status_change), 32'd0);
    chk("midrst_irq", 32'(irq), 32'd0);
    chk("midrst_ready", 32'(cfg_ready), 32'd0);
    resetn = 1'b1;
    cycle();
    chk("postrst_ready", 32'(cfg_ready), 32'd1);
    in = ~in;
    repeat (5) cycle();
    chk("postrst_no_cfg_kept", 32'(active), 32'd0);

    // Randomized traffic against the model
    for (int t = 0; t < 800; t++) begin
      if ($urandom_range(0, 2) == 0) in[$urandom_range(0, N_CH-1)] ^= 1'b1;
      cfg_valid   = ($urandom_range(0, 24) == 0);
      cfg_timeout = CNT_W'($urandom_range(0, 9));
      irq_ack     = ($urandom_range(0, 7) == 0);
      resetn      = ($urandom_range(0, 199) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
